// File: rtl/prod_accum_pkg.sv
// Shared definitions for the product accumulator: FSM state encoding,
// counter-width helper and the parameter legality predicate.
// Optional feature macro: PROD_ACCUM_SATURATE_EN (clamp instead of wrap).
package prod_accum_pkg;

  // ACCUM: taking products; HOLD: presenting a finished group sum.
  typedef enum logic {
    ACCUM = 1'b0,
    HOLD  = 1'b1
  } state_e;

  // Default group size; the counter width CNT_W is derived from it.
  localparam int CNT_DEFAULT = 4;
  localparam int CNT_W       = $clog2(CNT_DEFAULT);

  // Beat counter width for a given group size (counts 0..cnt-1).
  function automatic int cnt_w_f(input int cnt);
    return (cnt < 2) ? 1 : $clog2(cnt);
  endfunction

  // Legal parameter combinations for the accumulator.
  function automatic bit params_ok_f(input int in_w, input int cnt, input int acc_w);
    return (acc_w >= in_w) && (cnt >= 2) && (cnt <= 16);
  endfunction

endpackage

// File: rtl/prod_accum_add.sv
// Combinational ACC_W-bit adder: acc + zero-extended product.
// Optional feature macro: PROD_ACCUM_SATURATE_EN -- when defined the sum
// clamps to all-ones on carry; otherwise it wraps modulo 2^ACC_W.
module prod_accum_add #(
  parameter int IN_W  = 8,
  parameter int ACC_W = 10
) (
  input  logic [ACC_W-1:0] acc_i,
  input  logic [IN_W-1:0]  data_i,
  output logic [ACC_W-1:0] sum_o,
  output logic             carry_o
);

  logic [ACC_W:0] data_ext;
  logic [ACC_W:0] raw_sum;

  assign data_ext = {{(ACC_W + 1 - IN_W){1'b0}}, data_i};
  assign raw_sum  = {1'b0, acc_i} + data_ext;
  assign carry_o  = raw_sum[ACC_W];

`ifdef PROD_ACCUM_SATURATE_EN
  // Once the sum has clamped, every later non-zero add carries again and
  // re-clamps, so the value stays pinned at all-ones for the rest of the group.
  assign sum_o = raw_sum[ACC_W] ? {ACC_W{1'b1}} : raw_sum[ACC_W-1:0];
`else
  assign sum_o = raw_sum[ACC_W-1:0];
`endif

endmodule

// File: rtl/prod_accum.sv
// Product accumulator: sums groups of CNT unsigned products received on a
// valid/ready input and presents each group sum plus a sticky overflow flag
// on a valid/ready output.
// Optional feature macro: PROD_ACCUM_SATURATE_EN (see prod_accum_add).
//
// Handshake: a transfer happens on a rising clk edge where valid and ready
// are both 1; valid must not depend on ready. in_ready is 1 only in ACCUM,
// out_valid is 1 only in HOLD, so input and output never transfer in the
// same cycle.
module prod_accum
  import prod_accum_pkg::*;
#(
  parameter int IN_W  = 8,
  parameter int CNT   = 4,
  parameter int ACC_W = IN_W + $clog2(CNT)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_sum,
  output logic             out_ovf,
  output logic             busy
);

  localparam int              CW       = cnt_w_f(CNT);
  localparam logic [CW-1:0]   CNT_LAST = CW'(CNT - 1);

  // Elaboration-time rejection of illegal parameter sets.
  if (!params_ok_f(IN_W, CNT, ACC_W)) begin : g_param_check
    $fatal(1, "prod_accum: illegal parameters (need ACC_W >= IN_W and 2 <= CNT <= 16)");
  end

  state_e            state_q, state_d;
  logic [ACC_W-1:0]  acc_q, acc_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              ovf_q, ovf_d;
  logic [ACC_W-1:0]  sum_q, sum_d;
  logic              sum_ovf_q, sum_ovf_d;

  logic [ACC_W-1:0]  add_sum;
  logic              add_carry;

  prod_accum_add #(
    .IN_W  (IN_W),
    .ACC_W (ACC_W)
  ) u_add (
    .acc_i   (acc_q),
    .data_i  (in_data),
    .sum_o   (add_sum),
    .carry_o (add_carry)
  );

  // Next-state, datapath updates and handshake outputs.
  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    ovf_d     = ovf_q;
    sum_d     = sum_q;
    sum_ovf_d = sum_ovf_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;

    case (state_q)
      ACCUM: begin
        in_ready = 1'b1;
        if (in_valid) begin
          acc_d = add_sum;
          ovf_d = ovf_q | add_carry;
          if (cnt_q == CNT_LAST) begin
            // Last beat of the group: capture the updated values for output.
            cnt_d     = '0;
            sum_d     = add_sum;
            sum_ovf_d = ovf_q | add_carry;
            state_d   = HOLD;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end
      HOLD: begin
        out_valid = 1'b1;
        if (out_ready) begin
          acc_d   = '0;
          ovf_d   = 1'b0;
          state_d = ACCUM;
        end
      end
      default: begin
        state_d = ACCUM;
      end
    endcase
  end

  // State and datapath registers; reset discards partial and pending data.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= ACCUM;
      acc_q     <= '0;
      cnt_q     <= '0;
      ovf_q     <= 1'b0;
      sum_q     <= '0;
      sum_ovf_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
      ovf_q     <= ovf_d;
      sum_q     <= sum_d;
      sum_ovf_q <= sum_ovf_d;
    end
  end

  assign out_sum = sum_q;
  assign out_ovf = sum_ovf_q;
  assign busy    = (cnt_q != '0) || (state_q == HOLD);

endmodule

// File: tb/tb_prod_accum.sv
// Bench for prod_accum: two instances (default ACC_W=10 and ACC_W=9) share
// one stimulus stream; a reference model computes each group's expected
// sum/overflow from plain integer arithmetic and a monitor checks outputs.
module tb_prod_accum;

  localparam int IN_W = 8;
  localparam int CNT  = 4;
  localparam int AW_A = 10;
  localparam int AW_B = 9;

  logic            clk;
  logic            rst_n;
  logic            in_valid;
  logic [IN_W-1:0] in_data;
  logic            out_ready;
  logic            main_rdy;
  logic            rand_rdy_en;
  logic            rand_rdy;

  logic            in_ready_a, out_valid_a, out_ovf_a, busy_a;
  logic [AW_A-1:0] out_sum_a;
  logic            in_ready_b, out_valid_b, out_ovf_b, busy_b;
  logic [AW_B-1:0] out_sum_b;

  logic [AW_A:0]   exp_a_q[$];
  logic [AW_B:0]   exp_b_q[$];
  int              grp_q[$];

  int total;
  int bad;

  assign out_ready = rand_rdy_en ? rand_rdy : main_rdy;

  prod_accum #(.IN_W(IN_W), .CNT(CNT), .ACC_W(AW_A)) dut_a (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_a),
    .in_data(in_data), .out_valid(out_valid_a), .out_ready(out_ready),
    .out_sum(out_sum_a), .out_ovf(out_ovf_a), .busy(busy_a)
  );

  prod_accum #(.IN_W(IN_W), .CNT(CNT), .ACC_W(AW_B)) dut_b (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_b),
    .in_data(in_data), .out_valid(out_valid_b), .out_ready(out_ready),
    .out_sum(out_sum_b), .out_ovf(out_ovf_b), .busy(busy_b)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Random consumer readiness, used only during the random phase.
  initial rand_rdy = 1'b1;
  always @(posedge clk) begin
    #1;
    rand_rdy = ($urandom_range(0, 3) != 0);
  end

  // ---------------- checking helpers ----------------
  task automatic chk(input string nm, input int act, input int expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, expv, $time);
    end
  endtask

  // Reference: {ovf, sum} of a group whose products add up to grp_total.
  function automatic int model(input int grp_total, input int w);
    int mx;
    int s;
    bit o;
    mx = (1 << w) - 1;
    o  = (grp_total > mx);
`ifdef PROD_ACCUM_SATURATE_EN
    s = o ? mx : grp_total;
`else
    s = grp_total % (1 << w);
`endif
    return (int'(o) << w) | s;
  endfunction

  task automatic model_beat(input int d);
    int t;
    grp_q.push_back(d);
    if (grp_q.size() == CNT) begin
      t = 0;
      foreach (grp_q[i]) t += grp_q[i];
      exp_a_q.push_back((AW_A + 1)'(model(t, AW_A)));
      exp_b_q.push_back((AW_B + 1)'(model(t, AW_B)));
      grp_q.delete();
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic send_beat(input int d);
    int n;
    n        = 0;
    in_valid = 1'b1;
    in_data  = d[IN_W-1:0];
    @(negedge clk);
    while (!in_ready_a && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready_a) begin
      total++;
      bad++;
      $display("FAIL beat_timeout: got in_ready=0 expected in_ready=1 within 200 cycles");
      in_valid = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    model_beat(d);
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clk) begin : mon
    logic [AW_A:0] ea;
    logic [AW_B:0] eb;
    if (rst_n) begin
      chk("in_ready_a_vs_out_valid", int'(in_ready_a), int'(!out_valid_a));
      chk("in_ready_b_vs_out_valid", int'(in_ready_b), int'(!out_valid_b));
      if (out_valid_a) begin
        if (exp_a_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_a: got out_valid=1 expected no pending result");
        end else begin
          ea = exp_a_q[0];
          chk("sum_a", int'(out_sum_a), int'(ea[AW_A-1:0]));
          chk("ovf_a", int'(out_ovf_a), int'(ea[AW_A]));
          if (out_ready) void'(exp_a_q.pop_front());
        end
      end
      if (out_valid_b) begin
        if (exp_b_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_b: got out_valid=1 expected no pending result");
        end else begin
          eb = exp_b_q[0];
          chk("sum_b", int'(out_sum_b), int'(eb[AW_B-1:0]));
          chk("ovf_b", int'(out_ovf_b), int'(eb[AW_B]));
          if (out_ready) void'(exp_b_q.pop_front());
        end
      end
    end
  end

  // ---------------- main sequence ----------------
  initial begin
    int n;
    total       = 0;
    bad         = 0;
    rand_rdy_en = 1'b0;
    main_rdy    = 1'b0;
    rst_n       = 1'b0;
    in_valid    = 1'b1;
    in_data     = 8'd7;

    // Reset with in_valid high: nothing counted, outputs at reset values.
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_out_valid", int'(out_valid_a), 0);
    chk("rst_out_sum", int'(out_sum_a), 0);
    chk("rst_out_ovf", int'(out_ovf_a), 0);
    chk("rst_in_ready", int'(in_ready_a), 1);
    chk("rst_busy", int'(busy_a), 0);
    @(posedge clk);
    #1;
    rst_n    = 1'b1;
    in_valid = 1'b0;
    @(negedge clk);
    chk("post_rst_busy", int'(busy_a), 0);
    idle(1);

    // Basic group 225,1,0,100 with backpressure on the result.
    send_beat(225);
    send_beat(1);
    @(negedge clk);
    chk("busy_mid_group", int'(busy_a), 1);
    @(posedge clk);
    #1;
    send_beat(0);
    send_beat(100);
    in_valid = 1'b1;
    in_data  = 8'd99;
    @(negedge clk);
    chk("hold_out_valid", int'(out_valid_a), 1);
    chk("hold_in_ready", int'(in_ready_a), 0);
    chk("hold_busy", int'(busy_a), 1);
    repeat (5) @(negedge clk);
    @(posedge clk);
    #1;
    main_rdy = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    @(negedge clk);
    chk("after_hs_in_ready", int'(in_ready_a), 1);
    chk("after_hs_busy", int'(busy_a), 0);
    idle(1);

    // Four beats of 255 with gaps 0,2,3; overflows only the 9-bit instance.
    send_beat(255);
    send_beat(255);
    idle(2);
    send_beat(255);
    idle(3);
    send_beat(255);
    idle(3);

    // Reset mid-group discards the two partial beats.
    send_beat(50);
    send_beat(50);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    grp_q.delete();
    @(negedge clk);
    chk("mid_rst_busy", int'(busy_a), 0);
    @(posedge clk);
    #1;
    for (int i = 0; i < CNT; i++) send_beat(10);
    idle(3);

    // Random groups, random gaps, random consumer readiness.
    rand_rdy_en = 1'b1;
    for (int g = 0; g < 20; g++) begin
      for (int b = 0; b < CNT; b++) begin
        send_beat(int'($urandom_range(0, 255)));
        if ($urandom_range(0, 2) == 0) idle(int'($urandom_range(1, 3)));
      end
    end
    rand_rdy_en = 1'b0;
    main_rdy    = 1'b1;

    // Drain pending results.
    n = 0;
    while ((exp_a_q.size() != 0 || exp_b_q.size() != 0) && n < 50) begin
      @(posedge clk);
      n++;
    end
    idle(2);
    chk("drain_a_left", exp_a_q.size(), 0);
    chk("drain_b_left", exp_b_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
